// File: rtl/alu_ctrl.sv
// Operand/command controller feeding a combinational ALU: debounces the enter/sign
// buttons, captures operands A and B from the switches and sequences the function code.
module alu_ctrl #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       enter,
    input  logic       sign,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] FN,
    output logic       signed_mode,
    output logic       update
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IN_A,
        ST_IN_B,
        ST_ADD,
        ST_SUB,
        ST_MOD
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       enter_pulse;
    logic       sign_pulse;

    assign btn_raw     = {sign, enter};
    assign enter_pulse = btn_pulse[0];
    assign sign_pulse  = btn_pulse[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             level_q;
            logic             level_prev_q;
            logic             pulse_q;
            logic [CNT_W-1:0] cnt_q;

            // The counter only runs while the synchronized input disagrees with the
            // accepted level, so any bounce back to the accepted level restarts it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    pulse_q      <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    if (sync2_q == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        level_q <= ~level_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                    level_prev_q <= level_q;
                    pulse_q      <= level_q & ~level_prev_q;
                end
            end

            assign btn_pulse[gi] = pulse_q;
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       s_q, s_d;
    logic [3:0] fn_q, fn_d;
    logic       upd_q, upd_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IN_A;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            s_q     <= 1'b0;
            fn_q    <= 4'b0000;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            fn_q    <= fn_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        upd_d   = 1'b0;
        fn_d    = 4'b0000;

        // Sign is judged against the current state, so a simultaneous enter in IN_B
        // still ignores sign even though the next state is an arithmetic one.
        if (sign_pulse && (state_q inside {ST_ADD, ST_SUB, ST_MOD})) begin
            s_d   = ~s_q;
            upd_d = 1'b1;
        end

        if (enter_pulse) begin
            upd_d = 1'b1;
            case (state_q)
                ST_IN_A: begin
                    a_d     = din;
                    state_d = ST_IN_B;
                end
                ST_IN_B: begin
                    b_d     = din;
                    state_d = ST_ADD;
                end
                ST_ADD:  state_d = ST_SUB;
                ST_SUB:  state_d = ST_MOD;
                ST_MOD:  state_d = ST_ADD;
                default: state_d = ST_IN_A;
            endcase
        end

        case (state_d)
            ST_IN_A: fn_d = 4'b0000;
            ST_IN_B: fn_d = 4'b0001;
            ST_ADD:  fn_d = {s_d, 3'b010};
            ST_SUB:  fn_d = {s_d, 3'b011};
            ST_MOD:  fn_d = {s_d, 3'b100};
            default: fn_d = 4'b0000;
        endcase
    end

    assign A           = a_q;
    assign B           = b_q;
    assign FN          = fn_q;
    assign signed_mode = s_q;
    assign update      = upd_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized self-checking bench for alu_ctrl: button presses with bounce are checked
// against a press-level model of the operand/function-code sequence.
module tb_alu_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic       enter = 1'b0;
    logic       sign = 1'b0;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] FN;
    logic       signed_mode;
    logic       update;

    int n_total = 0;
    int n_bad   = 0;

    // Model: step 0 = entering A, 1 = entering B, 2/3/4 = add/sub/mod.
    int         m_st;
    bit         m_s;
    logic [7:0] m_a;
    logic [7:0] m_b;

    alu_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .din(din),
        .enter(enter),
        .sign(sign),
        .A(A),
        .B(B),
        .FN(FN),
        .signed_mode(signed_mode),
        .update(update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_fn(input int st, input bit s);
        if (st == 0) return 4'b0000;
        if (st == 1) return 4'b0001;
        return {s, 3'(st)};
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_s  = 1'b0;
        m_a  = 8'h00;
        m_b  = 8'h00;
    endtask

    task automatic model_step(input bit e, input bit s, input logic [7:0] d, output bit upd);
        upd = 1'b0;
        if (s && m_st >= 2) begin
            m_s = ~m_s;
            upd = 1'b1;
        end
        if (e) begin
            upd = 1'b1;
            case (m_st)
                0: begin m_a = d; m_st = 1; end
                1: begin m_b = d; m_st = 2; end
                4: m_st = 2;
                default: m_st = m_st + 1;
            endcase
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".A"}, A, m_a);
        check({tag, ".B"}, B, m_b);
        check({tag, ".FN"}, FN, model_fn(m_st, m_s));
        check({tag, ".s"}, signed_mode, m_s);
    endtask

    // Press with nb_p leading bounces and nb_r release bounces; the final rise is
    // driven at a negedge so the next posedge is the sampling edge k.
    task automatic do_press(input string tag, input bit e, input bit s, input logic [7:0] d,
                            input int nb_p, input int nb_r, input int extra);
        int n_upd;
        int first_at;
        bit exp_upd;
        @(negedge clk);
        din = d;
        for (int i = 0; i < nb_p; i++) begin
            enter = e; sign = s;
            @(negedge clk);
            enter = 1'b0; sign = 1'b0;
            @(negedge clk);
        end
        enter = e; sign = s;
        n_upd = 0;
        first_at = -1;
        for (int c = 1; c <= DEB + 4 + extra; c++) begin
            @(posedge clk); #1;
            if (update) begin
                n_upd++;
                if (first_at < 0) first_at = c;
            end
        end
        @(negedge clk);
        for (int i = 0; i < nb_r; i++) begin
            enter = 1'b0; sign = 1'b0;
            @(negedge clk);
            enter = e; sign = s;
            @(negedge clk);
        end
        enter = 1'b0; sign = 1'b0;
        for (int c = 0; c < 2 * DEB + 8; c++) begin
            @(posedge clk); #1;
            if (update) n_upd++;
        end
        model_step(e, s, d, exp_upd);
        check({tag, ".upd_cnt"}, n_upd, exp_upd ? 1 : 0);
        if (exp_upd) check({tag, ".latency"}, first_at, DEB + 4);
        check_state(tag);
        $display("txn %s enter=%0d sign=%0d din=%02h -> A=%02h B=%02h FN=%04b s=%0d updates=%0d",
                 tag, e, s, d, A, B, FN, signed_mode, n_upd);
    endtask

    initial begin
        int n_upd;
        bit u;
        model_reset();

        #2 reset_n = 1'b0;
        #1;
        check_state("reset");
        check("reset.upd", update, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        do_press("sign_in_a", 1'b0, 1'b1, 8'hEE, 0, 0, 0);
        do_press("enter_a", 1'b1, 1'b0, 8'h05, 0, 0, 0);
        do_press("enter_b", 1'b1, 1'b0, 8'h03, 2, 2, 12);

        @(negedge clk);
        enter = 1'b1;
        repeat (3) @(negedge clk);
        enter = 1'b0;
        n_upd = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (update) n_upd++;
        end
        check("glitch.upd_cnt", n_upd, 0);
        check_state("glitch");
        $display("txn glitch enter 3 cycles -> FN=%04b updates=%0d", FN, n_upd);

        do_press("op_sub", 1'b1, 1'b0, 8'hAA, 0, 0, 0);
        do_press("sign_sub", 1'b0, 1'b1, 8'hAA, 1, 1, 0);
        check("sign_sub.fn", FN, 4'b1011);
        do_press("sign_sub2", 1'b0, 1'b1, 8'hAA, 0, 0, 0);
        check("sign_sub2.fn", FN, 4'b0011);
        do_press("op_mod", 1'b1, 1'b0, 8'h11, 0, 0, 0);
        do_press("op_add", 1'b1, 1'b0, 8'h22, 0, 0, 0);
        do_press("both", 1'b1, 1'b1, 8'h33, 0, 0, 0);
        check("both.fn", FN, 4'b1011);

        for (int i = 0; i < 20; i++) begin
            bit         e;
            bit         s;
            logic [7:0] d;
            e = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (i == 5) begin
                @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
            end
            do_press("rand", e, s, d, $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 4));
        end

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        do_press("to_a", 1'b1, 1'b0, 8'h91, 0, 0, 0);
        do_press("to_b", 1'b1, 1'b0, 8'h22, 0, 0, 0);
        do_press("to_sub", 1'b1, 1'b0, 8'h00, 0, 0, 0);

        @(negedge clk);
        din = 8'h5A;
        enter = 1'b1;
        repeat (DEB + 4) @(posedge clk);
        #1;
        model_step(1'b1, 1'b0, 8'h5A, u);
        check("mod.upd", update, 1);
        check_state("mod");
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_state("rst_async");
        check("rst_async.upd", update, 0);
        $display("txn async reset in MOD -> A=%02h B=%02h FN=%04b upd=%0d", A, B, FN, update);

        @(negedge clk);
        din = 8'h44;
        @(negedge clk);
        reset_n = 1'b1;
        n_upd = 0;
        for (int c = 0; c < 3 * DEB + 10; c++) begin
            @(posedge clk); #1;
            if (update) n_upd++;
        end
        @(negedge clk);
        enter = 1'b0;
        for (int c = 0; c < 2 * DEB + 8; c++) begin
            @(posedge clk); #1;
            if (update) n_upd++;
        end
        model_step(1'b1, 1'b0, 8'h44, u);
        check("held.upd_cnt", n_upd, 1);
        check_state("held");
        $display("txn held through reset -> A=%02h FN=%04b updates=%0d", A, FN, n_upd);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
